// File: rtl/ddr3_pll_phase_stepper.sv
// rtl/ddr3_pll_phase_stepper.sv - DDR3 PHY PLL dynamic phase-shift sequencer
//
// Takes "shift counter N by K steps up/down" requests and sequences the PLL
// dynamic phase-shift pins one step at a time. Each step waits for the PLL
// phasedone handshake to go low and then high again. Both waits are bounded
// by a timeout. A signed, saturating phase offset is kept per counter so
// calibration can read back where each output currently sits.
//
// Ports:
//   scanclk             sole clock, rising edge
//   areset              asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_counter         target PLL counter index
//   req_updown          1 = shift up (+1 per step), 0 = shift down
//   req_steps           number of steps to issue
//   phasecounterselect  PLL counter select pin
//   phaseupdown         PLL direction pin
//   phasestep           PLL step strobe
//   phasedone           PLL step-complete handshake (asynchronous input)
//   busy                high whenever a request is in progress
//   done                one-cycle pulse when a request finishes
//   error               one-cycle pulse with done on a failed request
//   rd_counter          offset read-back index
//   rd_offset           signed accumulated offset of rd_counter (combinational)

module ddr3_pll_phase_stepper #(
  parameter int NUM_COUNTERS   = 7,
  parameter int SEL_WIDTH      = 4,
  parameter int STEPS_WIDTH    = 8,
  parameter int OFFSET_WIDTH   = 8,
  parameter int STEP_HOLD      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           scanclk,
  input  logic                           areset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SEL_WIDTH-1:0]           req_counter,
  input  logic                           req_updown,
  input  logic [STEPS_WIDTH-1:0]         req_steps,
  output logic [SEL_WIDTH-1:0]           phasecounterselect,
  output logic                           phaseupdown,
  output logic                           phasestep,
  input  logic                           phasedone,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  input  logic [SEL_WIDTH-1:0]           rd_counter,
  output logic signed [OFFSET_WIDTH-1:0] rd_offset
);

  localparam int HOLD_W = (STEP_HOLD < 1) ? 1 : $clog2(STEP_HOLD + 1);
  localparam int TMO_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [OFFSET_WIDTH-1:0] OFF_MAX = {1'b0, {(OFFSET_WIDTH-1){1'b1}}};
  localparam logic signed [OFFSET_WIDTH-1:0] OFF_MIN = {1'b1, {(OFFSET_WIDTH-1){1'b0}}};
  localparam logic signed [OFFSET_WIDTH-1:0] OFF_ONE = OFFSET_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_FIN
  } state_t;

  state_t                         state;
  logic [SEL_WIDTH-1:0]           cur_counter;
  logic                           cur_up;
  logic [STEPS_WIDTH-1:0]         remaining;
  logic [HOLD_W-1:0]              hold_cnt;
  logic [TMO_W-1:0]               tmo_cnt;
  logic                           pd_meta;
  logic                           pd_sync;
  logic signed [OFFSET_WIDTH-1:0] offset [NUM_COUNTERS];
  logic                           req_legal;
  logic                           tmo_hit;

  // Widened compare so NUM_COUNTERS == 2**SEL_WIDTH still works.
  assign req_legal = ({1'b0, req_counter} < (SEL_WIDTH + 1)'(NUM_COUNTERS));
  // True on the wait cycle whose increment makes the counter reach the limit.
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  function automatic logic signed [OFFSET_WIDTH-1:0] sat_step(
    input logic signed [OFFSET_WIDTH-1:0] v,
    input logic                           up
  );
    if (up) begin
      return (v == OFF_MAX) ? v : v + OFF_ONE;
    end
    return (v == OFF_MIN) ? v : v - OFF_ONE;
  endfunction

  // phasedone comes straight from the PLL; idle level is high, so the
  // synchroniser resets to 1 to avoid a fake low after reset.
  always_ff @(posedge scanclk or posedge areset) begin
    if (areset) begin
      pd_meta <= 1'b1;
      pd_sync <= 1'b1;
    end else begin
      pd_meta <= phasedone;
      pd_sync <= pd_meta;
    end
  end

  always_ff @(posedge scanclk or posedge areset) begin
    if (areset) begin
      state              <= S_IDLE;
      req_ready          <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      phasestep          <= 1'b0;
      phaseupdown        <= 1'b0;
      phasecounterselect <= '0;
      cur_counter        <= '0;
      cur_up             <= 1'b0;
      remaining          <= '0;
      hold_cnt           <= '0;
      tmo_cnt            <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        offset[i] <= '0;
      end
    end else begin
      // done/error are high only for the single cycle spent in FIN.
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur_counter <= req_counter;
            cur_up      <= req_updown;
            remaining   <= req_steps;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            if (!req_legal) begin
              state <= S_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (req_steps == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              // Pins only move for a request that will actually step.
              state              <= S_SETUP;
              phasecounterselect <= req_counter;
              phaseupdown        <= req_updown;
            end
          end
        end

        S_SETUP: begin
          state     <= S_STEP;
          phasestep <= 1'b1;
          hold_cnt  <= HOLD_W'(1);
        end

        S_STEP: begin
          if (hold_cnt == HOLD_W'(STEP_HOLD)) begin
            phasestep <= 1'b0;
            state     <= S_WAIT_LOW;
            tmo_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_WAIT_LOW: begin
          if (!pd_sync) begin
            state   <= S_WAIT_HIGH;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
              state <= S_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end

        S_WAIT_HIGH: begin
          if (pd_sync) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
              if (cur_counter == SEL_WIDTH'(i)) begin
                offset[i] <= sat_step(offset[i], cur_up);
              end
            end
            remaining <= remaining - STEPS_WIDTH'(1);
            if (remaining == STEPS_WIDTH'(1)) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_SETUP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
              state <= S_FIN;
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end

        S_FIN: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          phasestep <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range read-back indices return zero.
  always_comb begin
    rd_offset = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rd_counter == SEL_WIDTH'(i)) begin
        rd_offset = offset[i];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_pll_phase_stepper.sv
// tb/tb_ddr3_pll_phase_stepper.sv - scoreboard bench for the PLL phase stepper

module tb_ddr3_pll_phase_stepper;

  localparam int NC   = 7;
  localparam int SW   = 4;
  localparam int STW  = 8;
  localparam int OW   = 4;
  localparam int HOLD = 2;
  localparam int TMO  = 255;
  localparam int OMAX = (1 << (OW - 1)) - 1;
  localparam int OMIN = -(1 << (OW - 1));

  logic                  scanclk;
  logic                  areset;
  logic                  req_valid;
  logic                  req_ready;
  logic [SW-1:0]         req_counter;
  logic                  req_updown;
  logic [STW-1:0]        req_steps;
  logic [SW-1:0]         phasecounterselect;
  logic                  phaseupdown;
  logic                  phasestep;
  logic                  phasedone;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [SW-1:0]         rd_counter;
  logic signed [OW-1:0]  rd_offset;

  ddr3_pll_phase_stepper #(
    .NUM_COUNTERS  (NC),
    .SEL_WIDTH     (SW),
    .STEPS_WIDTH   (STW),
    .OFFSET_WIDTH  (OW),
    .STEP_HOLD     (HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .scanclk           (scanclk),
    .areset            (areset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_counter       (req_counter),
    .req_updown        (req_updown),
    .req_steps         (req_steps),
    .phasecounterselect(phasecounterselect),
    .phaseupdown       (phaseupdown),
    .phasestep         (phasestep),
    .phasedone         (phasedone),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .rd_counter        (rd_counter),
    .rd_offset         (rd_offset)
  );

  typedef struct {
    int counter;
    bit ud;
    int pulses;
    bit err;
    bit timeout;
    int off;
  } exp_t;

  exp_t sbq[$];
  int   model_off [NC];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  bit   stuck    = 0;
  int   fix_d1   = 0;
  int   fix_d2   = 0;

  // monitor state
  bit   m_ps_prev = 0;
  int   m_hi      = 0;
  int   m_pulses  = 0;
  int   m_sel_prev = 0;
  int   m_last_fall = 0;
  exp_t m_e;

  initial begin
    scanclk = 0;
    forever #5 scanclk = ~scanclk;
  end

  always @(posedge scanclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  // PLL phasedone model: after each phasestep, drop phasedone for a while and
  // bring it back. When stuck, phasedone never leaves 1.
  initial begin
    int d1;
    int d2;
    phasedone = 1'b1;
    forever begin
      @(negedge scanclk);
      if (phasestep && !stuck && !areset) begin
        d1 = (fix_d1 != 0) ? fix_d1 : $urandom_range(1, 5);
        d2 = (fix_d2 != 0) ? fix_d2 : $urandom_range(1, 6);
        repeat (d1) @(negedge scanclk);
        phasedone = 1'b0;
        repeat (d2) @(negedge scanclk);
        phasedone = 1'b1;
        while (phasestep) @(negedge scanclk);
      end
    end
  end

  // Monitor: watches PLL pins and pops the scoreboard on every done pulse.
  initial begin
    forever begin
      @(negedge scanclk);
      if (areset) begin
        m_ps_prev  = 1'b0;
        m_hi       = 0;
        m_pulses   = 0;
        m_sel_prev = phasecounterselect;
      end else begin
        if (phasestep && !m_ps_prev) begin
          m_pulses++;
          m_hi = 1;
          if (sbq.size() == 0) begin
            check("unexpected_phasestep", 1, 0);
          end else begin
            check("select_setup", m_sel_prev, sbq[0].counter);
            check("updown_pin", phaseupdown, sbq[0].ud);
          end
        end else if (phasestep) begin
          m_hi++;
        end else if (m_ps_prev) begin
          check("step_width", m_hi, HOLD);
          m_last_fall = cyc;
        end
        check("error_only_with_done", error & ~done, 0);
        if (done) begin
          if (sbq.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            m_e = sbq.pop_front();
            check("done_error", error, m_e.err);
            check("pulse_count", m_pulses, m_e.pulses);
            check("busy_at_done", busy, 1);
            check("ready_at_done", req_ready, 0);
            if (m_e.timeout) check("timeout_latency", cyc - m_last_fall, TMO);
            rd_counter = m_e.counter[SW-1:0];
            #1;
            check("rd_offset", int'($signed(rd_offset)), m_e.off);
          end
          m_pulses = 0;
          done_cnt++;
        end
        m_ps_prev  = phasestep;
        m_sel_prev = phasecounterselect;
      end
    end
  end

  task automatic do_req(input int c, input bit ud, input int s, input bit stuck_mode, input bit poke);
    exp_t e;
    int   n;
    int   start_done;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge scanclk);
      n++;
    end
    check("ready_before_req", req_ready, 1);
    e.counter = c;
    e.ud      = ud;
    e.timeout = 0;
    if (c >= NC) begin
      e.err = 1; e.pulses = 0; e.off = 0;
    end else if (s == 0) begin
      e.err = 0; e.pulses = 0; e.off = model_off[c];
    end else if (stuck_mode) begin
      e.err = 1; e.pulses = 1; e.timeout = 1; e.off = model_off[c];
    end else begin
      model_off[c] = clamp(model_off[c] + (ud ? s : -s));
      e.err = 0; e.pulses = s; e.off = model_off[c];
    end
    stuck = stuck_mode;
    sbq.push_back(e);
    start_done  = done_cnt;
    req_counter = c[SW-1:0];
    req_updown  = ud;
    req_steps   = s[STW-1:0];
    req_valid   = 1'b1;
    @(negedge scanclk);
    req_valid = 1'b0;
    if (poke) begin
      // A request presented while busy must be ignored.
      req_valid   = 1'b1;
      req_counter = SW'($urandom_range(0, NC - 1));
      req_steps   = 8'd1;
      @(negedge scanclk);
      req_valid = 1'b0;
    end
    n = 0;
    while (done_cnt == start_done && n < 3000) begin
      @(negedge scanclk);
      n++;
    end
    if (done_cnt == start_done) begin
      check("done_wait_bound", 0, 1);
      sbq.delete();
    end
    stuck = 0;
  endtask

  initial begin
    int c;
    int s;
    int n;
    for (int i = 0; i < NC; i++) model_off[i] = 0;
    areset      = 1'b1;
    req_valid   = 1'b0;
    req_counter = '0;
    req_updown  = 1'b0;
    req_steps   = '0;
    rd_counter  = '0;
    repeat (3) @(negedge scanclk);
    areset = 1'b0;
    @(negedge scanclk);

    check("reset_req_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_phasestep", phasestep, 0);
    check("reset_done", done, 0);
    check("reset_select", phasecounterselect, 0);
    for (int i = 0; i < NC; i++) begin
      rd_counter = i[SW-1:0];
      #1;
      check("reset_rd_offset", int'($signed(rd_offset)), 0);
    end
    @(negedge scanclk);

    // single step with fixed phasedone timing
    fix_d1 = 3; fix_d2 = 4;
    do_req(2, 1'b1, 1, 1'b0, 1'b0);
    fix_d1 = 0; fix_d2 = 0;
    // multi-step down and back
    do_req(5, 1'b0, 3, 1'b0, 1'b0);
    do_req(5, 1'b1, 3, 1'b0, 1'b1);
    // saturation
    do_req(0, 1'b1, 10, 1'b0, 1'b0);
    // timeout after first step
    do_req(4, 1'b1, 4, 1'b1, 1'b0);
    // illegal and degenerate
    do_req(9, 1'b1, 2, 1'b0, 1'b0);
    do_req(3, 1'b0, 0, 1'b0, 1'b1);

    for (int k = 0; k < 30; k++) begin
      c = ($urandom_range(0, 9) == 0) ? $urandom_range(NC, 15) : $urandom_range(0, NC - 1);
      s = $urandom_range(0, 6);
      do_req(c, 1'($urandom_range(0, 1)), s, 1'b0, ($urandom_range(0, 2) == 0));
    end

    // reset in the middle of a step
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge scanclk);
      n++;
    end
    begin
      exp_t e;
      e.counter = 3; e.ud = 1; e.pulses = 3; e.err = 0; e.timeout = 0; e.off = 0;
      sbq.push_back(e);
    end
    req_counter = 4'd3; req_updown = 1'b1; req_steps = 8'd3; req_valid = 1'b1;
    @(negedge scanclk);
    req_valid = 1'b0;
    n = 0;
    while (!phasestep && n < 100) begin
      @(negedge scanclk);
      n++;
    end
    check("mid_reset_step_seen", phasestep, 1);
    #2;
    areset = 1'b1;
    #1;
    check("async_phasestep_drop", phasestep, 0);
    sbq.delete();
    for (int i = 0; i < NC; i++) model_off[i] = 0;
    repeat (3) @(negedge scanclk);
    areset = 1'b0;
    @(negedge scanclk);
    check("post_reset_ready", req_ready, 1);
    check("post_reset_busy", busy, 0);
    for (int i = 0; i < NC; i++) begin
      rd_counter = i[SW-1:0];
      #1;
      check("post_reset_rd_offset", int'($signed(rd_offset)), 0);
    end
    repeat (20) @(negedge scanclk);
    do_req(2, 1'b0, 2, 1'b0, 1'b0);
    repeat (5) @(negedge scanclk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_pll_phase_stepper.md
Name: ddr3_pll_phase_stepper

Overview:
Multi-counter dynamic phase-shift sequencer for the DDR3 PHY PLL. It accepts a request of the form "shift counter N by K steps up or down" and drives the PLL phasecounterselect/phaseupdown/phasestep pins. It tracks each step through the PLL phasedone handshake, with a timeout on every wait. It keeps a signed per-counter accumulated phase offset for calibration read-back.

Parameters:
NUM_COUNTERS, 7, number of PLL output counters (c0..c6) that can be shifted
SEL_WIDTH, 4, width of the counter select and of the phasecounterselect pin
STEPS_WIDTH, 8, width of the requested step count
OFFSET_WIDTH, 8, width of the signed per-counter accumulated offset
STEP_HOLD, 2, scanclk cycles phasestep is held high per step (legal range 1 or more)
TIMEOUT_CYCLES, 255, maximum scanclk cycles spent in either phasedone wait state

Ports:
scanclk  input  1  sole clock; all logic is on the rising edge
areset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_counter  input  SEL_WIDTH  target counter index
req_updown  input  1  1 = shift up (offset +1 per step), 0 = shift down
req_steps  input  STEPS_WIDTH  number of steps
phasecounterselect  output  SEL_WIDTH  to PLL
phaseupdown  output  1  to PLL
phasestep  output  1  to PLL
phasedone  input  1  from PLL, asynchronous; passes through a 2-flop synchroniser
busy  output  1  high whenever state is not IDLE
done  output  1  1-cycle pulse when a request finishes (success or error)
error  output  1  1-cycle pulse, coincident with done, on a failed request
rd_counter  input  SEL_WIDTH  offset read-back index
rd_offset  output  OFFSET_WIDTH  signed offset of rd_counter; combinational

Behaviour:
- Reset values (asynchronous): state IDLE, req_ready 1, phasestep 0, phaseupdown 0, phasecounterselect 0, busy 0, done 0, error 0, all offsets 0, synchroniser flops 1.
- A request is accepted on a rising edge where req_valid && req_ready. Accepting it registers counter, direction and remaining = req_steps.
- If req_counter >= NUM_COUNTERS at accept: next state is FIN with error. No PLL pin toggles.
- If req_steps == 0 at accept: next state is FIN without error. No pins toggle and offsets are unchanged.
- Otherwise the next state is SETUP. phasecounterselect and phaseupdown update on the accept edge and hold until the next accepted request, including while IDLE.
- SETUP: 1 cycle of select/direction setup before the step. Next state is STEP with phasestep 1.
- STEP: phasestep stays high for exactly STEP_HOLD cycles, then drops. Next state is WAIT_LOW, and the timeout counter clears.
- WAIT_LOW: wait for synchronised phasedone == 0, then go to WAIT_HIGH with the timeout counter cleared.
- WAIT_HIGH: wait for synchronised phasedone == 1. On that cycle the target offset updates by +1 (up) or -1 (down), saturating at +2^(OFFSET_WIDTH-1)-1 and -2^(OFFSET_WIDTH-1). remaining decrements. If remaining reaches 0, go to FIN; otherwise go to SETUP.
- Timeout: the timeout counter increments each cycle in WAIT_LOW and WAIT_HIGH. If it reaches TIMEOUT_CYCLES before the awaited level, go to FIN with error. Remaining steps are abandoned, the offset is not updated for the failed step, and updates for completed steps are kept.
- FIN: done = 1 for one cycle, plus error = 1 if flagged. Next state is IDLE. req_ready returns high the cycle after done.
- Requests are never queued; req_valid while busy is ignored.
- rd_offset returns 0 when rd_counter >= NUM_COUNTERS.
- areset asserted mid-request: phasestep drops immediately (asynchronously), the request is lost and offsets clear. No done is generated.
- Minimum per-step time with ideal phasedone: 1 + STEP_HOLD + 2 (synchroniser) + wait cycles.

Test Plan:
- Reset: hold areset for 3 cycles, then release -> req_ready=1, busy=0, phasestep=0, rd_offset=0 for counters 0..6.
- Single step: req counter 2, up, steps 1; phasedone model drops 3 cycles after phasestep rises and recovers 4 cycles later -> phasecounterselect=2 one cycle before phasestep, phasestep high exactly 2 cycles, one done pulse with error=0, rd_offset[2]=+1.
- Multi-step down: counter 5, steps 3 -> 3 separate phasestep pulses, each separated by a full phasedone low/high cycle, rd_offset[5]=-3, then a second 3-step up request brings it back to 0.
- Saturation: OFFSET_WIDTH=4, counter 0, up, steps 10 -> 10 phasestep pulses, rd_offset[0]=+7, done with error=0.
- Timeout: phasedone stuck at 1 after the first phasestep; request of 4 steps -> done+error exactly TIMEOUT_CYCLES cycles after entering WAIT_LOW, only 1 phasestep pulse issued, offset unchanged.
- Illegal and degenerate requests: counter 9 -> done+error with no phasestep; steps 0 -> done, error=0, no phasestep. In a separate run, areset asserted during STEP -> phasestep drops immediately, all offsets read 0, req_ready=1 after release.
